// File: rtl/rst_req_pkg.sv
// Shared definitions for the reset-request controller.
//   - rst_req_state_e : controller FSM states
//   - Src*            : bit index of each request source in req_i / cause_o
//   - Def*            : default parameter values
package rst_req_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAssert,
        StWaitHigh,
        StHoldoff
    } rst_req_state_e;

    localparam int unsigned SrcSw   = 0;
    localparam int unsigned SrcWdog = 1;
    localparam int unsigned SrcDbg  = 2;

    localparam int unsigned DefNumSrc        = 3;
    localparam int unsigned DefPulseCycles   = 8;
    localparam int unsigned DefTimeoutCycles = 32;
    localparam int unsigned DefHoldoffCycles = 4;

endpackage

// File: rtl/rst_req_edge_det.sv
// Rising-edge detector for a bus of request levels.
//   clk_i      : clock
//   rst_ni     : asynchronous active-low reset
//   req_i      : request levels
//   new_req_o  : one-cycle strobe per bit on a 0->1 transition of req_i
// The history register resets to ResetVal (all-ones by default) so a level that
// is already high when reset releases is not reported as an edge.
module rst_req_edge_det #(
    parameter int unsigned       Width    = 1,
    parameter logic [Width-1:0]  ResetVal = '1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] req_i,
    output logic [Width-1:0] new_req_o
);

    logic [Width-1:0] req_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q <= ResetVal;
        end else begin
            req_q <= req_i;
        end
    end

    assign new_req_o = req_i & ~req_q;

endmodule

// File: rtl/rst_req_ctrl.sv
// Reset-request controller issuing non-debug-module resets.
//   clk_i       : clock (power-on domain)
//   rst_ni      : asynchronous active-low power-on reset
//   req_i       : request levels (sw, watchdog, debug); rising edge = request
//   sys_rst_ni  : system reset feedback from the reset manager (active-low)
//   cause_clr_i : single-cycle pulse clearing cause_o
//   ndmreset_o  : registered reset request, high only while asserting
//   busy_o      : high whenever a sequence is in progress
//   cause_o     : sticky OR of sources that requested resets
//   timeout_o   : one-cycle pulse when a wait phase expires
// The block is never reset by sys_rst_ni so it survives the reset it issues.
module rst_req_ctrl
    import rst_req_pkg::*;
#(
    parameter int unsigned NumSrc        = DefNumSrc,
    parameter int unsigned PulseCycles   = DefPulseCycles,
    parameter int unsigned TimeoutCycles = DefTimeoutCycles,
    parameter int unsigned HoldoffCycles = DefHoldoffCycles
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumSrc-1:0] req_i,
    input  logic              sys_rst_ni,
    input  logic              cause_clr_i,
    output logic              ndmreset_o,
    output logic              busy_o,
    output logic [NumSrc-1:0] cause_o,
    output logic              timeout_o
);

    localparam int unsigned CntW = $clog2(TimeoutCycles);

    localparam logic [CntW-1:0] CntTimeout = CntW'(TimeoutCycles - 1);
    localparam logic [CntW-1:0] CntHoldoff = CntW'(HoldoffCycles - 1);
    // Counting the current cycle as elapsed, PulseCycles have passed in ASSERT
    // once cnt has fallen to TimeoutCycles-PulseCycles.
    localparam logic [CntW-1:0] CntPulseMet = CntW'(TimeoutCycles - PulseCycles);
    localparam logic [CntW-1:0] CntOne      = CntW'(1);

    logic [NumSrc-1:0] new_req;

    rst_req_edge_det #(
        .Width    (NumSrc),
        .ResetVal ({NumSrc{1'b1}})
    ) u_edge_det (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (req_i),
        .new_req_o (new_req)
    );

    rst_req_state_e    state_q;
    logic [CntW-1:0]   cnt_q;
    logic              seen_low_q;
    logic [NumSrc-1:0] pend_q;
    logic [NumSrc-1:0] cause_q;
    logic              ndmreset_q;
    logic              busy_q;
    logic              timeout_q;

    logic seen_now;
    logic pulse_met;
    logic cnt_zero;

    always_comb begin
        seen_now  = seen_low_q | ~sys_rst_ni;
        pulse_met = (cnt_q <= CntPulseMet);
        cnt_zero  = (cnt_q == '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            seen_low_q <= 1'b0;
            pend_q     <= '0;
            cause_q    <= '0;
            ndmreset_q <= 1'b0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;

            // Any new edge is recorded as a cause; a coincident clear loses to it.
            if (cause_clr_i) begin
                cause_q <= new_req;
            end else begin
                cause_q <= cause_q | new_req;
            end

            unique case (state_q)
                StIdle: begin
                    if ((|new_req) || (|pend_q)) begin
                        state_q    <= StAssert;
                        cnt_q      <= CntTimeout;
                        seen_low_q <= 1'b0;
                        pend_q     <= '0;
                        ndmreset_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end

                StAssert: begin
                    if (!sys_rst_ni) begin
                        seen_low_q <= 1'b1;
                    end
                    if (seen_now && pulse_met) begin
                        state_q    <= StWaitHigh;
                        cnt_q      <= CntTimeout;
                        ndmreset_q <= 1'b0;
                    end else if (cnt_zero) begin
                        state_q    <= StHoldoff;
                        cnt_q      <= CntHoldoff;
                        ndmreset_q <= 1'b0;
                        timeout_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CntOne;
                    end
                end

                StWaitHigh: begin
                    if (sys_rst_ni) begin
                        state_q <= StHoldoff;
                        cnt_q   <= CntHoldoff;
                    end else if (cnt_zero) begin
                        state_q   <= StHoldoff;
                        cnt_q     <= CntHoldoff;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CntOne;
                    end
                end

                StHoldoff: begin
                    // Requests arriving here are replayed from IDLE.
                    pend_q <= pend_q | new_req;
                    if (cnt_zero) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CntOne;
                    end
                end

                default: begin
                    state_q    <= StIdle;
                    ndmreset_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign ndmreset_o = ndmreset_q;
    assign busy_o     = busy_q;
    assign cause_o    = cause_q;
    assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_rst_req_ctrl.sv
module tb_rst_req_ctrl;
    import rst_req_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [2:0] req_i;
    logic       sys_rst_ni;
    logic       cause_clr_i;
    logic       ndmreset_o;
    logic       busy_o;
    logic [2:0] cause_o;
    logic       timeout_o;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk_i = ~clk_i;

    rst_req_ctrl #(
        .NumSrc        (3),
        .PulseCycles   (8),
        .TimeoutCycles (32),
        .HoldoffCycles (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .sys_rst_ni  (sys_rst_ni),
        .cause_clr_i (cause_clr_i),
        .ndmreset_o  (ndmreset_o),
        .busy_o      (busy_o),
        .cause_o     (cause_o),
        .timeout_o   (timeout_o)
    );

    // Model reset manager: sys_rst_ni follows ~ndmreset_o two cycles later.
    logic d1, d2;
    logic force_high = 1'b0;
    logic hold_low   = 1'b0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            d1 <= 1'b0;
            d2 <= 1'b0;
        end else begin
            d1 <= ndmreset_o;
            d2 <= d1;
        end
    end

    assign sys_rst_ni = force_high | (~d2 & ~hold_low);

    int to_seen = 0;
    always @(posedge clk_i) begin
        if (timeout_o === 1'b1) to_seen++;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Further cycles ndmreset_o stays high (bounded).
    task automatic count_ndm(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (ndmreset_o !== 1'b1) break;
            n++;
        end
    endtask

    // Ticks until busy_o is low, including the tick where it drops.
    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            n++;
            if (busy_o !== 1'b1) break;
        end
    endtask

    task automatic count_until_timeout(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            n++;
            if (timeout_o === 1'b1) break;
        end
    endtask

    task automatic count_until_ndm(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            n++;
            if (ndmreset_o === 1'b1) break;
        end
    endtask

    initial begin
        int n;
        int snap;

        rst_ni      = 1'b0;
        req_i       = 3'b000;
        cause_clr_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_ndm", ndmreset_o, 0);
        check("reset_busy", busy_o, 0);
        check("reset_cause", cause_o, 0);
        check("reset_timeout", timeout_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        // 1: software request, normal handshake.
        snap = to_seen;
        req_i = 3'b001;
        tick();
        check("sw_ndm_rise", ndmreset_o, 1);
        check("sw_busy_rise", busy_o, 1);
        req_i = 3'b000;
        count_ndm(n);
        check("sw_ndm_width", n + 1, 8);
        check("sw_busy_at_fall", busy_o, 1);
        count_busy(n);
        check("sw_busy_tail", n, 7);
        check("sw_cause", cause_o, 3'b001);
        check("sw_no_timeout", to_seen - snap, 0);

        // cause clear
        cause_clr_i = 1'b1;
        tick();
        cause_clr_i = 1'b0;
        check("cause_clr", cause_o, 0);

        // 2: reset manager never responds -> timeout in ASSERT.
        force_high = 1'b1;
        snap = to_seen;
        req_i = 3'b001;
        tick();
        req_i = 3'b000;
        count_ndm(n);
        check("to_assert_width", n + 1, 32);
        check("to_assert_pulse", timeout_o, 1);
        count_busy(n);
        check("to_assert_holdoff", n, 4);
        check("to_assert_count", to_seen - snap, 1);
        force_high = 1'b0;

        // 3: sys_rst_ni stuck low -> timeout in WAIT_HIGH.
        hold_low = 1'b1;
        snap = to_seen;
        req_i = 3'b001;
        tick();
        req_i = 3'b000;
        count_ndm(n);
        check("to_wait_ndm_width", n + 1, 8);
        count_until_timeout(n);
        check("to_wait_len", n, 32);
        check("to_wait_ndm_low", ndmreset_o, 0);
        count_busy(n);
        check("to_wait_holdoff", n, 4);
        check("to_wait_count", to_seen - snap, 1);
        hold_low = 1'b0;
        tick();

        // 4: watchdog edge during ASSERT merges into one sequence.
        req_i = 3'b001;
        tick();
        check("merge_ndm_rise", ndmreset_o, 1);
        tick();
        tick();
        req_i = 3'b011;
        count_ndm(n);
        check("merge_ndm_width", n + 3, 8);
        count_busy(n);
        check("merge_busy_tail", n, 7);
        repeat (6) tick();
        check("merge_no_second", busy_o, 0);
        check("merge_cause", cause_o, 3'b011);

        // 5: clear coincident with new request, then debug edge in HOLDOFF.
        req_i = 3'b000;
        tick();
        req_i = 3'b001;
        cause_clr_i = 1'b1;
        tick();
        cause_clr_i = 1'b0;
        check("clr_vs_req_cause", cause_o, 3'b001);
        count_ndm(n);
        check("pend_first_width", n + 1, 8);
        repeat (4) tick();
        req_i = 3'b101;
        count_until_ndm(n);
        check("pend_restart_delay", n, 4);
        check("pend_cause", cause_o, 3'b101);
        count_ndm(n);
        check("pend_second_width", n + 1, 8);
        count_busy(n);
        check("pend_busy_tail", n, 7);

        // 6: power-on reset mid-ASSERT with a request level held.
        req_i = 3'b000;
        tick();
        req_i = 3'b001;
        tick();
        check("por_ndm_rise", ndmreset_o, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("por_ndm_async", ndmreset_o, 0);
        check("por_busy", busy_o, 0);
        check("por_cause", cause_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (5) tick();
        check("por_held_no_trig", ndmreset_o, 0);
        check("por_held_no_busy", busy_o, 0);
        req_i = 3'b000;
        tick();
        req_i = 3'b100;
        tick();
        check("por_new_edge", ndmreset_o, 1);
        req_i = 3'b000;
        count_busy(n);
        check("por_cause_dbg", cause_o[SrcDbg], 1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
